// File: rtl/mine_placer.sv
// Minesweeper mine-field generator: places NUM_MINES mines on a GRID_SIZE x GRID_SIZE
// board using a free-running 16-bit Galois LFSR, never mining the first-click tile.
module mine_placer #(
  parameter int          GRID_SIZE     = 5,
  parameter int          TOTAL_SQUARES = GRID_SIZE * GRID_SIZE,
  parameter int          INDEX_WIDTH   = $clog2(TOTAL_SQUARES),
  parameter int          NUM_MINES     = 5,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [INDEX_WIDTH-1:0]   safe_index,
  output logic [TOTAL_SQUARES-1:0] mine_map,
  output logic [INDEX_WIDTH:0]     mine_count,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [INDEX_WIDTH:0] LAST_COUNT = (INDEX_WIDTH + 1)'(NUM_MINES - 1);

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic [15:0]              lfsr;
  logic [INDEX_WIDTH-1:0]   safe_q;
  logic [INDEX_WIDTH-1:0]   candidate;
  logic [TOTAL_SQUARES-1:0] cand_hit;
  logic                     cand_accept;
  logic                     take_start;

  // One-hot decode of the candidate; an all-zero result means it is off the board.
  always_comb begin
    candidate = lfsr[INDEX_WIDTH-1:0];
    cand_hit  = '0;
    for (int unsigned i = 0; i < TOTAL_SQUARES; i++) begin
      cand_hit[i] = (candidate == INDEX_WIDTH'(i));
    end
    cand_accept = (|cand_hit) && (candidate != safe_q) && !(|(cand_hit & mine_map));
  end

  assign take_start = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CLEAR;
      S_CLEAR: state_next = (NUM_MINES == 0) ? S_DONE : S_PLACE;
      S_PLACE: if (cand_accept && (mine_count == LAST_COUNT)) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_CLEAR;
      default: state_next = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_CLEAR) || (state_next == S_PLACE);
      done  <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_INIT;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      safe_q <= '0;
    end else if (take_start) begin
      safe_q <= safe_index;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mine_map   <= '0;
      mine_count <= '0;
    end else if (state == S_CLEAR) begin
      mine_map   <= '0;
      mine_count <= '0;
    end else if ((state == S_PLACE) && cand_accept) begin
      mine_map   <= mine_map | cand_hit;
      mine_count <= mine_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: three configurations (5, 24 and 0 mines) checked every cycle
// against a timeline model of each generation request, plus directed literal checks.
module tb_mine_placer;
  localparam int TS = 25;
  localparam int IW = 5;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [IW-1:0] safe_index;

  logic [TS-1:0] map_o  [NI];
  logic [IW:0]   cnt_o  [NI];
  logic          busy_o [NI];
  logic          done_o [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  mine_placer #(.NUM_MINES(5)) dut0 (
    .clk(clk), .rst(rst), .start(start), .safe_index(safe_index),
    .mine_map(map_o[0]), .mine_count(cnt_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  mine_placer #(.NUM_MINES(24), .SEED(16'h0000)) dut1 (
    .clk(clk), .rst(rst), .start(start), .safe_index(safe_index),
    .mine_map(map_o[1]), .mine_count(cnt_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  mine_placer #(.NUM_MINES(0), .SEED(16'h1234)) dut2 (
    .clk(clk), .rst(rst), .start(start), .safe_index(safe_index),
    .mine_map(map_o[2]), .mine_count(cnt_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  // ---------------- reference model ----------------
  logic [15:0]   m_lfsr   [NI];
  logic [TS-1:0] m_map    [NI];
  int            m_cnt    [NI];
  bit            m_busy   [NI];
  bit            m_done   [NI];
  bit            m_active [NI];
  int            m_age    [NI];
  int            m_safe   [NI];

  function automatic int mines_of(input int k);
    return (k == 0) ? 5 : (k == 1) ? 24 : 0;
  endfunction

  function automatic logic [15:0] seed_of(input int k);
    return (k == 0) ? 16'hACE1 : (k == 1) ? 16'h0001 : 16'h1234;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic void model_reset(input int k);
    m_lfsr[k] = seed_of(k);
    m_map[k] = '0; m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    m_active[k] = 0; m_age[k] = 0; m_safe[k] = 0;
  endfunction

  function automatic void model_finish(input int k);
    m_active[k] = 0; m_busy[k] = 0; m_done[k] = 1;
  endfunction

  // m_age counts clock edges since the request was accepted:
  // edge 1 wipes the old field, each later edge offers one LFSR candidate.
  function automatic void model_step(input int k);
    logic [15:0] cur;
    int c;
    cur = m_lfsr[k];
    m_lfsr[k] = lfsr_step(cur);
    if (m_active[k]) begin
      m_age[k]++;
      if (m_age[k] == 1) begin
        m_map[k] = '0; m_cnt[k] = 0;
        if (mines_of(k) == 0) model_finish(k);
      end else begin
        c = int'(cur[IW-1:0]);
        if (c < TS && c != m_safe[k] && !m_map[k][c]) begin
          m_map[k][c] = 1'b1;
          m_cnt[k]++;
          if (m_cnt[k] == mines_of(k)) model_finish(k);
        end
      end
    end else if (start) begin
      m_active[k] = 1; m_age[k] = 0; m_safe[k] = int'(safe_index);
      m_busy[k] = 1; m_done[k] = 0;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst) model_reset(k);
      else model_step(k);
    end
  end

  // ---------------- checking ----------------
  function automatic void check(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < NI; k++) begin
        check("mine_map", k, 32'(map_o[k]), 32'(m_map[k]));
        check("mine_count", k, 32'(cnt_o[k]), 32'(m_cnt[k]));
        check("busy", k, 32'(busy_o[k]), 32'(m_busy[k]));
        check("done", k, 32'(done_o[k]), 32'(m_done[k]));
      end
    end
  end

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    while (done_o[k] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", k, 32'(done_o[k]), 32'd1);
  endtask

  task automatic pulse_start(input logic [IW-1:0] s);
    @(negedge clk);
    start = 1'b1; safe_index = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; start = 1'b0; safe_index = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checking = 1'b1;

    // First post-reset cycle: reset values and LFSR seed.
    check("reset_map", 0, 32'(map_o[0]), 32'h0);
    check("reset_count", 0, 32'(cnt_o[0]), 32'h0);
    check("reset_busy", 0, 32'(busy_o[0]), 32'h0);
    check("reset_done", 0, 32'(done_o[0]), 32'h0);
    check("lfsr_seed", 0, 32'(dut0.lfsr), 32'hACE1);
    check("lfsr_seed_zero", 1, 32'(dut1.lfsr), 32'h0001);
    @(negedge clk);
    check("model_lfsr_step", 0, 32'(m_lfsr[0]), 32'hE270);
    check("idle_without_start", 0, 32'(busy_o[0]), 32'h0);

    // safe_index 12, with start hammered (random safe_index) while dut0 is busy.
    start = 1'b1; safe_index = 5'd12;
    @(negedge clk);
    check("zero_mines_t1", 2, 32'(done_o[2]), 32'h0);
    check("busy_after_start", 0, 32'(busy_o[0]), 32'h1);
    for (int c = 0; c < 2000 && busy_o[0] === 1'b1; c++) begin
      start = 1'b1; safe_index = IW'($urandom_range(0, 31));
      @(negedge clk);
      if (c == 0) check("zero_mines_t2", 2, 32'(done_o[2]), 32'h1);
    end
    start = 1'b0;
    wait_done(0, 10);
    check("pop_5", 0, 32'($countones(map_o[0])), 32'd5);
    check("count_5", 0, 32'(cnt_o[0]), 32'd5);
    check("safe12_clear", 0, 32'(map_o[0][12]), 32'h0);
    wait_done(1, 20000);
    check("map24_safe12", 1, 32'(map_o[1]), 32'h1FFEFFF);
    repeat (20) @(negedge clk);
    check("stable_pop_5", 0, 32'($countones(map_o[0])), 32'd5);
    check("stable_safe12", 0, 32'(map_o[0][12]), 32'h0);

    // safe_index 0: the 24-mine field must be every tile but tile 0.
    pulse_start(5'd0);
    wait_done(0, 2000);
    wait_done(1, 20000);
    check("map24_safe0", 1, 32'(map_o[1]), 32'h1FFFFFE);
    check("count24", 1, 32'(cnt_o[1]), 32'd24);
    check("safe0_clear", 0, 32'(map_o[0][0]), 32'h0);

    // Random start pulses and safe indices, including off-board ones.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      safe_index = IW'($urandom_range(0, 31));
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NI; k++) wait_done(k, 20000);

    // Reset in the middle of placement, once two mines are down.
    pulse_start(IW'($urandom_range(0, 24)));
    for (int c = 0; c < 2000 && !(busy_o[0] === 1'b1 && cnt_o[0] == 2); c++) @(negedge clk);
    check("reached_two_mines", 0, 32'(cnt_o[0]), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("abort_map", 0, 32'(map_o[0]), 32'h0);
    check("abort_busy", 0, 32'(busy_o[0]), 32'h0);
    check("abort_done", 0, 32'(done_o[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 0, 32'(busy_o[0]), 32'h0);

    // Regenerate from DONE: done must drop during the wipe cycle.
    pulse_start(5'd7);
    wait_done(0, 2000);
    pulse_start(5'd3);
    check("regen_done_low", 0, 32'(done_o[0]), 32'h0);
    check("regen_busy", 0, 32'(busy_o[0]), 32'h1);
    wait_done(0, 2000);
    check("regen_safe3", 0, 32'(map_o[0][3]), 32'h0);
    wait_done(1, 20000);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
